// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks the register file through one asynchronous read port after a
//   program halts. Each (index, value) pair is streamed over a valid/ready
//   interface, and a running checksum/count of emitted words is kept.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           request a scan (only honoured while idle)
//   rd_addr/rd_data register-file read port (rd_addr is the scan index)
//   out_valid/out_ready/out_addr/out_data   word stream
//   busy            high while scanning or draining the last word
//   done            one-cycle pulse when the scan completes
//   checksum, count sum (mod 2^32) and number of emitted words
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SKIP_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    output logic [5:0]  count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
    localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

    logic [1:0] state;
    logic [4:0] idx;
    logic       load;
    logic       emit;

    // The output slot can take a new word when it is empty or being consumed.
    assign load    = !out_valid || out_ready;
    assign emit    = (SKIP_ZERO == 0) || (rd_data != 32'h0);
    assign rd_addr = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= FIRST_IDX;
            out_valid <= 1'b0;
            out_addr  <= 5'd0;
            out_data  <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= 32'h0;
            count     <= 6'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SCAN;
                        busy     <= 1'b1;
                        idx      <= FIRST_IDX;
                        checksum <= 32'h0;
                        count    <= 6'd0;
                    end
                end
                S_SCAN: begin
                    if (load) begin
                        if (emit) begin
                            out_valid <= 1'b1;
                            out_addr  <= idx;
                            out_data  <= rd_data;
                            checksum  <= checksum + rd_data;
                            count     <= count + 6'd1;
                        end else begin
                            // Any held word was consumed this cycle, so the
                            // slot is simply emptied.
                            out_valid <= 1'b0;
                        end
                        if (idx == LAST_IDX) begin
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Wait for the final word to leave before signalling done.
                    if (load) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                        idx       <= FIRST_IDX;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    idx       <= FIRST_IDX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: three instances (full range, zero-skipping,
// 8..9 subrange) share one register-file model. A reference model computes
// the expected word list from the register contents; a negedge monitor pops
// and compares every accepted word and checks hold-stability under stalls.
module tb_regfile_dump_reader;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic [2:0]       start;
    logic [2:0]       v, bsy, dn;
    logic [2:0][4:0]  ra, oa;
    logic [2:0][31:0] rdd, od, cs;
    logic [2:0][5:0]  cn;

    logic [31:0] regs  [32];
    logic [31:0] mregs [32];

    logic [36:0] q [$];
    logic [31:0] exp_sum;
    int          exp_cnt;
    int          n_chk = 0, n_pass = 0;
    int          cyc = 0, pops = 0, last_acc = -1;
    int          rmode = 0, pcnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdd[0] = (ra[0] == 5'd0) ? 32'h0 : regs[ra[0]];
    assign rdd[1] = (ra[1] == 5'd0) ? 32'h0 : regs[ra[1]];
    assign rdd[2] = (ra[2] == 5'd0) ? 32'h0 : regs[ra[2]];

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .rd_addr(ra[0]), .rd_data(rdd[0]),
        .out_valid(v[0]), .out_ready(rdy), .out_addr(oa[0]), .out_data(od[0]),
        .busy(bsy[0]), .done(dn[0]), .checksum(cs[0]), .count(cn[0]));

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .SKIP_ZERO(1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .rd_addr(ra[1]), .rd_data(rdd[1]),
        .out_valid(v[1]), .out_ready(rdy), .out_addr(oa[1]), .out_data(od[1]),
        .busy(bsy[1]), .done(dn[1]), .checksum(cs[1]), .count(cn[1]));

    regfile_dump_reader #(.FIRST_REG(8), .LAST_REG(9), .SKIP_ZERO(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .rd_addr(ra[2]), .rd_data(rdd[2]),
        .out_valid(v[2]), .out_ready(rdy), .out_addr(oa[2]), .out_data(od[2]),
        .busy(bsy[2]), .done(dn[2]), .checksum(cs[2]), .count(cn[2]));

    task automatic chk(input bit ok, input string name, input logic [63:0] got,
                       input logic [63:0] expv);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] expv);
        chk(got == expv, name, got, expv);
    endtask

    // ready generator: 0 = always ready, 1 = 1,0,0,1,0 repeating, 2 = random
    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((pcnt % 5) == 0) || ((pcnt % 5) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pcnt++;
        end
    end

    // Monitor: every accepted word is popped from the scoreboard.
    logic [2:0]       pv;
    logic [2:0][4:0]  pa;
    logic [2:0][31:0] pd;
    logic             prdy = 1'b0, prst = 1'b1;
    initial pv = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!prst && pv[k] && !prdy)
                chk(v[k] && oa[k] == pa[k] && od[k] == pd[k], "stall_hold",
                    {v[k], oa[k], od[k]}, {1'b1, pa[k], pd[k]});
            if (v[k] && rdy) begin
                if (q.size() == 0) begin
                    chk(1'b0, "extra_word", {oa[k], od[k]}, 64'h0);
                end else begin
                    logic [36:0] e;
                    e = q.pop_front();
                    cmp("word", {oa[k], od[k]}, e);
                end
                pops++;
                last_acc = cyc + 1;
            end
        end
        pv   <= v;
        pa   <= oa;
        pd   <= od;
        prdy <= rdy;
        prst <= rst;
    end

    // Reference model: the word list a scan of instance k should emit.
    task automatic build_exp(input int k);
        int f, l;
        bit s;
        logic [31:0] val;
        case (k)
            1:       begin f = 0; l = 31; s = 1'b1; end
            2:       begin f = 8; l = 9;  s = 1'b0; end
            default: begin f = 0; l = 31; s = 1'b0; end
        endcase
        exp_sum = 32'h0;
        exp_cnt = 0;
        for (int i = f; i <= l; i++) begin
            val = (i == 0) ? 32'h0 : mregs[i];
            if (!(s && val == 32'h0)) begin
                q.push_back({5'(i), val});
                exp_sum = exp_sum + val;
                exp_cnt++;
            end
        end
    endtask

    task automatic load_regs();
        mregs[0] = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = mregs[i];
    endtask

    // Returns at posedge+1 just after the edge that samples start.
    task automatic begin_scan(input int k, input int mode);
        rmode = mode;
        build_exp(k);
        @(posedge clk);
        #1 start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic finish_scan(input int k, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (dn[k]) seen = 1'b1;
        end
        chk(seen, {tag, "_done_seen"}, 64'(seen), 64'h1);
        if (seen) begin
            cmp({tag, "_done_timing"}, 64'(last_acc), 64'(cyc));
            cmp({tag, "_busy_low"}, 64'(bsy[k]), 64'h0);
            cmp({tag, "_valid_low"}, 64'(v[k]), 64'h0);
            cmp({tag, "_checksum"}, 64'(cs[k]), 64'(exp_sum));
            cmp({tag, "_count"}, 64'(cn[k]), 64'(exp_cnt));
            cmp({tag, "_remaining"}, 64'(q.size()), 64'h0);
            @(negedge clk);
            cmp({tag, "_done_pulse"}, 64'(dn[k]), 64'h0);
        end
    endtask

    initial begin
        int p0;
        bit ok, bad;
        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'(3 * i);
        load_regs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // reset state
        for (int k = 0; k < 3; k++) begin
            cmp("rst_valid", 64'(v[k]), 64'h0);
            cmp("rst_busy_done", 64'({bsy[k], dn[k]}), 64'h0);
            cmp("rst_sum_cnt", {26'h0, cn[k], cs[k]}, 64'h0);
            cmp("rst_out", {oa[k], od[k]}, 64'h0);
            cmp("rst_rd_addr", 64'(ra[k]), (k == 2) ? 64'd8 : 64'd0);
        end

        // full scan, always ready, with first-word latency
        begin_scan(0, 0);
        @(negedge clk);
        cmp("lat_e0_valid", 64'(v[0]), 64'h0);
        cmp("lat_e0_busy", 64'(bsy[0]), 64'h1);
        @(negedge clk);
        cmp("lat_e1_valid", 64'(v[0]), 64'h1);
        finish_scan(0, "full");
        cmp("full_sum_const", 64'(cs[0]), 64'd1488);

        // backpressure pattern
        begin_scan(0, 1);
        finish_scan(0, "bp");
        cmp("bp_count_const", 64'(cn[0]), 64'd32);

        // random contents, random ready
        for (int i = 1; i < 32; i++) mregs[i] = $urandom;
        load_regs();
        begin_scan(0, 2);
        finish_scan(0, "rand");

        // skip zeros
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mregs[5]  = 32'hDEADBEEF;
        mregs[31] = 32'h1;
        load_regs();
        begin_scan(1, 2);
        finish_scan(1, "skip");
        cmp("skip_sum_const", 64'(cs[1]), 64'hDEADBEF0);

        // skip zeros with random sparse contents
        for (int i = 1; i < 32; i++) mregs[i] = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
        mregs[31] = 32'h55;
        load_regs();
        begin_scan(1, 2);
        finish_scan(1, "skip_rand");

        // subrange with checksum wrap
        mregs[8] = 32'hFFFFFFFF;
        mregs[9] = 32'h2;
        load_regs();
        begin_scan(2, 2);
        finish_scan(2, "sub");
        cmp("sub_sum_const", {26'h0, cn[2], cs[2]}, {26'h0, 6'd2, 32'h1});

        // reset mid-scan, then rescan
        for (int i = 0; i < 32; i++) mregs[i] = 32'(3 * i);
        load_regs();
        begin_scan(0, 0);
        p0 = pops;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (pops - p0 >= 10) ok = 1'b1;
        end
        chk(ok, "mid_ten_words", 64'(pops - p0), 64'd10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp("mid_rst_valid", 64'(v[0]), 64'h0);
        cmp("mid_rst_busy", 64'(bsy[0]), 64'h0);
        cmp("mid_rst_sum_cnt", {26'h0, cn[0], cs[0]}, 64'h0);
        q.delete();
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dn[0] || bsy[0] || v[0]) bad = 1'b1;
        end
        chk(!bad, "mid_quiet", 64'(bad), 64'h0);
        begin_scan(0, 1);
        finish_scan(0, "rescan");

        // start while busy, plus write to r20 two cycles before it is read
        mregs[20] = 32'd7;
        begin_scan(0, 0);
        repeat (8) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 regs[20] = 32'd7;
        finish_scan(0, "wr");
        cmp("wr_sum_const", 64'(cs[0]), 64'd1435);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bsy[0] || v[0]) bad = 1'b1;
        end
        chk(!bad, "start_ignored", 64'(bad), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential reader that walks the MIPS register file through one of its asynchronous read ports.
- Streams each (register index, value) pair out over a valid/ready interface and accumulates a checksum.
- Sits beside the register file as the debug/test-bench-visible reader. The datapath writes the file; this block drains it after a program halts.
- When idle, the block drives no meaningful read address; the read-port mux selecting between datapath and dumper is outside this block.

Parameters:
- FIRST_REG, 0, first register index scanned (0..31).
- LAST_REG, 31, last register index scanned. Must satisfy FIRST_REG <= LAST_REG <= 31.
- SKIP_ZERO, 0, when 1, registers whose value is 32'h0 are not emitted and not counted.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- rd_addr  out  5  register-file read address, combinationally equal to the current index.
- rd_data  in  32  register-file read data, combinational response to rd_addr.
- out_valid  out  1  out_addr/out_data hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_addr  out  5  register index of the emitted word.
- out_data  out  32  register value of the emitted word.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse when the scan completes.
- checksum  out  32  sum mod 2^32 of all emitted out_data in the current or last scan.
- count  out  6  number of words emitted in the current or last scan.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: rst is sampled on the rising edge of clk and has priority over everything.
  - Reset values: state=IDLE, idx=FIRST_REG, out_valid=0, out_addr=0, out_data=0, busy=0, done=0, checksum=0, count=0.
  - rd_addr=idx, so it reads FIRST_REG after reset.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - start=1 -> SCAN; idx<=FIRST_REG, checksum<=0, count<=0.
  - done is low in every cycle except the completion pulse.
- SCAN, load condition L = (!out_valid || out_ready).
  - If L:
    - Sample rd_data at the edge.
    - If emitting (SKIP_ZERO=0 or rd_data!=0): out_valid<=1, out_addr<=idx, out_data<=rd_data, checksum<=checksum+rd_data (carry discarded), count<=count+1.
    - If skipping: out_valid<=0, because any held word was consumed this cycle.
    - If idx==LAST_REG -> DRAIN, else idx<=idx+1.
  - If !L: all state holds. out_valid, out_addr and out_data must stay stable while out_valid=1 and out_ready=0.
- DRAIN:
  - When (!out_valid || out_ready): out_valid<=0, done<=1 for exactly one cycle, -> IDLE, idx<=FIRST_REG.
  - checksum and count are retained until the next start.
- busy = (state!=IDLE), registered alongside state.
- Throughput and latency:
  - With out_ready held at 1: one word per cycle.
  - The first out_valid rises on the second edge after start is sampled.
- Register-file writes during a scan are permitted. Each word carries the value present at its load edge; no snapshot is taken.
- start in SCAN or DRAIN is ignored; no restart and no queuing.
- A reset mid-scan aborts immediately: out_valid=0 after that edge, no done pulse, and checksum and count are cleared.
- Register 0 reads 0, so it is skipped when SKIP_ZERO=1.
- Arithmetic widths:
  - idx is 5 bits and never wraps past LAST_REG.
  - count is 6 bits so that 32 fits.

Test Plan:
- Full scan: preload regs[i]=3*i, out_ready=1, pulse start -> addrs 0..31 in consecutive cycles, out_data=3*i, checksum=1488, count=32, done one cycle after the last word's acceptance, busy low afterward.
- Backpressure: same preload, out_ready pattern 1,0,0,1,0,1,... -> no word lost or duplicated, and out_addr/out_data are held stable while stalled. Final checksum=1488, count=32.
- Skip zeros: SKIP_ZERO=1, only r5=32'hDEADBEEF and r31=1 nonzero -> exactly 2 words (5, DEADBEEF) and (31, 1), checksum=32'hDEADBEF0, count=2.
- Subrange with overflow: FIRST_REG=8, LAST_REG=9, r8=32'hFFFFFFFF, r9=2 -> 2 words, checksum=1 (wraps), count=2.
- Reset mid-scan: assert rst for one cycle after 10 words emitted -> out_valid=0, busy=0, checksum=0, count=0, no done pulse. A new start rescans from FIRST_REG.
- start while busy, plus concurrent write: pulse start again mid-scan -> ignored. Write r20=7 two cycles before idx reaches 20 -> word 20 reports 7.
